not_gate_checker: RTL and testbench
===================================

// Module: not_gate_checker
// PURPOSE
//  Drive side and check side of the inverter interface: generates every input pattern
//  for a WIDTH-bit inverter DUT on stim_o and samples the DUT output on resp_i.
//  Each response must equal ~stim_o. Sits on the board/test top next to not1-style gates.
//  Reports per-run error count and pass/fail over a start/done handshake.
// PARAMETERS
//  WIDTH   1   DUT bus width, legal 1..16; sweeps 2**WIDTH patterns
//  SETTLE  2   cycles stim_o is held before resp_i is sampled, legal >= 1
//  ERR_W   16  width of err_count; saturates at all-ones
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  start      in   1      run request; sampled only in IDLE
//  stim_o     out  WIDTH  stimulus to DUT input (registered)
//  resp_i     in   WIDTH  DUT output, sampled in CHECK
//  busy       out  1      high in SETTLE and CHECK
//  done       out  1      one-cycle pulse in DONE
//  pass       out  1      1 if last run had zero mismatches; held until next start
//  err_count  out  ERR_W  mismatches in current/last run
//  fail_stim  out  WIDTH  (NOT_CHK_FAIL_CAPTURE_EN only) first failing stimulus
//  fail_resp  out  WIDTH  (NOT_CHK_FAIL_CAPTURE_EN only) response seen for it
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, stim_o=0, busy=0, done=0, pass=0, err_count=0.
//  FSM states: IDLE, SETTLE, CHECK, DONE.
//  IDLE: start=1 -> SETTLE; stim_o<=0, err_count<=0, pass<=0, settle_cnt<=SETTLE-1.
//  SETTLE: stim_o held; settle_cnt==0 -> CHECK, else settle_cnt-1. Lasts exactly SETTLE cycles.
//  CHECK: one cycle; if resp_i != ~stim_o then err_count+1 (saturating at 2**ERR_W-1).
//   stim_o==all-ones -> DONE; else stim_o<=stim_o+1, settle_cnt<=SETTLE-1 -> SETTLE.
//  DONE: done=1 for one cycle; pass<=(final err_count==0) incl. last CHECK result; -> IDLE.
//  Latency: start sampled at edge 0 -> done high in cycle 1 + 2**WIDTH*(SETTLE+1).
//   WIDTH=1,SETTLE=2: done in cycle 7.
//  start while busy or in DONE: ignored, no queueing. start held high: new run begins
//   the cycle after DONE.
//  Wrap: stim_o never wraps; all-ones pattern is checked, then run ends.
//  Reset mid-run: run aborted, no done pulse, err_count cleared.
//  err_count/pass remain stable in IDLE for readback.
// CONFIGURATION
//  `NOT_CHK_FAIL_CAPTURE_EN defined: fail_stim/fail_resp ports exist; at the first
//   mismatch of a run they latch stim_o/resp_i; later mismatches don't overwrite;
//   cleared to 0 on reset and on accepted start.
//  Not defined: ports and registers absent; all other behaviour identical.
// STRUCTURE
//  Package not_chk_pkg: state enum (IDLE,SETTLE,CHECK,DONE), 2-bit state width constant.
//  One sub-module: not_chk_sat_counter (ERR_W-bit saturating incrementer with clear).
//  Reference model for compare is ~stim_o inline; no DUT inside this block.
// TESTING
//  1 WIDTH=1,SETTLE=2, correct inverter tied in: start pulse -> stim_o 0 then 1,
//    done in cycle 7, pass=1, err_count=0.
//  2 WIDTH=4, resp_i tied to stim_o (buffer) -> 16 mismatches, err_count=16, pass=0.
//  3 WIDTH=4, inverter with bit2 stuck-at-0 -> err_count=8; with capture_EN
//    fail_stim=4'h0, fail_resp=4'hB.
//  4 ERR_W=2, WIDTH=3, buffer DUT -> err_count saturates at 3, pass=0.
//  5 rst_n low in SETTLE of pattern 5 (WIDTH=3) -> all outputs reset same cycle
//    asynchronously, no done; restart gives full clean run.
//  6 start re-pulsed while busy -> ignored, single done; start held high -> back-to-back
//    runs, second begins cycle after DONE.

Source files
------------

// File: rtl/not_chk_pkg.sv
// ============================================================================
// Module   : not_chk_pkg
// Brief    : Shared state encoding for the inverter checker.
// Revision : 1.0
// ============================================================================
`default_nettype none

package not_chk_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/not_chk_sat_counter.sv
// ============================================================================
// Module   : not_chk_sat_counter
// Brief    : ERR_W-bit incrementer that sticks at all-ones, with sync clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module not_chk_sat_counter #(
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [ERR_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {ERR_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/not_gate_checker.sv
// ============================================================================
// Module   : not_gate_checker
// Brief    : Sweeps every WIDTH-bit pattern into an inverter and checks
//            resp_i == ~stim_o. Optional macro NOT_CHK_FAIL_CAPTURE_EN adds
//            first-failure capture ports fail_stim/fail_resp.
// Revision : 1.0
// ============================================================================
`default_nettype none

module not_gate_checker
    import not_chk_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int SETTLE = 2,
    parameter int ERR_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] stim_o,
    input  logic [WIDTH-1:0] resp_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
`ifdef NOT_CHK_FAIL_CAPTURE_EN
    output logic [WIDTH-1:0] fail_stim,
    output logic [WIDTH-1:0] fail_resp,
`endif
    output logic [ERR_W-1:0] err_count
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] settle_cnt;
    logic             mismatch;
    logic             last_pattern;
    logic             run_accept;
    logic             err_inc;

    assign mismatch     = (resp_i != ~stim_o);
    assign last_pattern = (stim_o == {WIDTH{1'b1}});
    assign run_accept   = (state == ST_IDLE) && start;
    assign err_inc      = (state == ST_CHECK) && mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                busy = 1'b1;
                if (settle_cnt == '0) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                busy       = 1'b1;
                state_next = last_pattern ? ST_DONE : ST_SETTLE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // pass is resolved on the final CHECK edge so it already holds during DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim_o     <= '0;
            settle_cnt <= '0;
            pass       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        stim_o     <= '0;
                        settle_cnt <= SETTLE_LOAD;
                        pass       <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (last_pattern) begin
                        pass <= (err_count == '0) && !mismatch;
                    end else begin
                        stim_o     <= stim_o + 1'b1;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    not_chk_sat_counter #(
        .ERR_W (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (run_accept),
        .inc   (err_inc),
        .count (err_count)
    );

`ifdef NOT_CHK_FAIL_CAPTURE_EN
    logic fail_seen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_stim <= '0;
            fail_resp <= '0;
            fail_seen <= 1'b0;
        end else if (run_accept) begin
            fail_stim <= '0;
            fail_resp <= '0;
            fail_seen <= 1'b0;
        end else if (err_inc && !fail_seen) begin
            fail_stim <= stim_o;
            fail_resp <= resp_i;
            fail_seen <= 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_not_gate_checker.sv
// ============================================================================
// Module   : tb_not_gate_checker
// Brief    : Directed self-checking bench; three checker instances with
//            different WIDTH/ERR_W share clock and reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_not_gate_checker;

    logic clk;
    logic rst_n;

    // instance A: WIDTH=1, SETTLE=2, correct inverter
    logic       start_a;
    logic [0:0] stim_a, resp_a;
    logic       busy_a, done_a, pass_a;
    logic [15:0] err_a;

    // instance B: WIDTH=4, SETTLE=2, ERR_W=16
    logic       start_b;
    logic [3:0] stim_b, resp_b;
    logic       busy_b, done_b, pass_b;
    logic [15:0] err_b;
    logic [1:0] mode_b;

    // instance C: WIDTH=3, SETTLE=2, ERR_W=2
    logic       start_c;
    logic [2:0] stim_c, resp_c;
    logic       busy_c, done_c, pass_c;
    logic [1:0] err_c;
    logic [1:0] mode_c;

`ifdef NOT_CHK_FAIL_CAPTURE_EN
    logic [0:0] fs_a, fr_a;
    logic [3:0] fs_b, fr_b;
    logic [2:0] fs_c, fr_c;
`endif

    int tests_run;
    int tests_failed;

    // mode: 0 inverter, 1 buffer, 2 inverter with bit2 stuck at 0
    assign resp_a = ~stim_a;
    always_comb begin
        case (mode_b)
            2'd1:    resp_b = stim_b;
            2'd2:    resp_b = ~stim_b & 4'b1011;
            default: resp_b = ~stim_b;
        endcase
        case (mode_c)
            2'd1:    resp_c = stim_c;
            default: resp_c = ~stim_c;
        endcase
    end

    not_gate_checker #(.WIDTH(1), .SETTLE(2), .ERR_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .stim_o(stim_a), .resp_i(resp_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
`ifdef NOT_CHK_FAIL_CAPTURE_EN
        .fail_stim(fs_a), .fail_resp(fr_a),
`endif
        .err_count(err_a)
    );

    not_gate_checker #(.WIDTH(4), .SETTLE(2), .ERR_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stim_o(stim_b), .resp_i(resp_b),
        .busy(busy_b), .done(done_b), .pass(pass_b),
`ifdef NOT_CHK_FAIL_CAPTURE_EN
        .fail_stim(fs_b), .fail_resp(fr_b),
`endif
        .err_count(err_b)
    );

    not_gate_checker #(.WIDTH(3), .SETTLE(2), .ERR_W(2)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .stim_o(stim_c), .resp_i(resp_c),
        .busy(busy_c), .done(done_c), .pass(pass_c),
`ifdef NOT_CHK_FAIL_CAPTURE_EN
        .fail_stim(fs_c), .fail_resp(fr_c),
`endif
        .err_count(err_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Raises start for edge 0, then counts cycles until done (-1 on timeout).
    task automatic run_until_done(input int which, output int cycles);
        logic d;
        cycles = -1;
        @(negedge clk);
        case (which)
            1:       start_b = 1'b1;
            2:       start_c = 1'b1;
            default: start_a = 1'b1;
        endcase
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
            start_c = 1'b0;
            case (which)
                1:       d = done_b;
                2:       d = done_c;
                default: d = done_a;
            endcase
            if (d) begin
                cycles = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({stim_a, busy_a, done_a, pass_a} !== 4'b0000 || err_a !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_a: got stim=%0h busy=%0b done=%0b pass=%0b err=%0d, expected all 0",
                     stim_a, busy_a, done_a, pass_a, err_a);
        end
        tests_run++;
        if (stim_b !== 4'h0 || {busy_b, done_b, pass_b} !== 3'b000 || err_b !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_b: got stim=%0h busy=%0b done=%0b pass=%0b err=%0d, expected all 0",
                     stim_b, busy_b, done_b, pass_b, err_b);
        end
`ifdef NOT_CHK_FAIL_CAPTURE_EN
        tests_run++;
        if (fs_b !== 4'h0 || fr_b !== 4'h0) begin
            tests_failed++;
            $display("FAIL reset_capture: got %0h/%0h, expected 0/0", fs_b, fr_b);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_inverter_w1();
        logic exp_busy, exp_done;
        logic [0:0] exp_stim;
        @(negedge clk);
        start_a = 1'b1;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            start_a  = 1'b0;
            exp_done = (cyc == 7);
            exp_busy = (cyc >= 1 && cyc <= 6);
            tests_run++;
            if (done_a !== exp_done || busy_a !== exp_busy) begin
                tests_failed++;
                $display("FAIL w1_timing cyc%0d: got busy=%0b done=%0b, expected busy=%0b done=%0b",
                         cyc, busy_a, done_a, exp_busy, exp_done);
            end
            if (cyc <= 6) begin
                exp_stim = (cyc <= 3) ? 1'b0 : 1'b1;
                tests_run++;
                if (stim_a !== exp_stim) begin
                    tests_failed++;
                    $display("FAIL w1_stim cyc%0d: got %0b, expected %0b", cyc, stim_a, exp_stim);
                end
            end
        end
        tests_run++;
        if (pass_a !== 1'b1 || err_a !== 16'd0) begin
            tests_failed++;
            $display("FAIL w1_result: got pass=%0b err=%0d, expected pass=1 err=0", pass_a, err_a);
        end
    endtask

    task automatic test_buffer_w4();
        int cycles;
        mode_b = 2'd1;
        run_until_done(1, cycles);
        tests_run++;
        if (cycles != 49) begin
            tests_failed++;
            $display("FAIL w4_buffer_latency: got %0d cycles, expected 49", cycles);
        end
        @(negedge clk);
        tests_run++;
        if (err_b !== 16'd16 || pass_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL w4_buffer_result: got err=%0d pass=%0b, expected err=16 pass=0", err_b, pass_b);
        end
        tests_run++;
        if (busy_b !== 1'b0 || stim_b !== 4'hF) begin
            tests_failed++;
            $display("FAIL w4_idle_hold: got busy=%0b stim=%0h, expected busy=0 stim=f", busy_b, stim_b);
        end
    endtask

    task automatic test_stuck_w4();
        int cycles;
        mode_b = 2'd2;
        run_until_done(1, cycles);
        @(negedge clk);
        tests_run++;
        if (cycles != 49 || err_b !== 16'd8 || pass_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL w4_stuck: got cycles=%0d err=%0d pass=%0b, expected 49/8/0", cycles, err_b, pass_b);
        end
`ifdef NOT_CHK_FAIL_CAPTURE_EN
        tests_run++;
        if (fs_b !== 4'h0 || fr_b !== 4'hB) begin
            tests_failed++;
            $display("FAIL w4_capture: got stim=%0h resp=%0h, expected 0/b", fs_b, fr_b);
        end
`endif
        // a clean run afterwards must restore pass and clear the count
        mode_b = 2'd0;
        run_until_done(1, cycles);
        @(negedge clk);
        tests_run++;
        if (err_b !== 16'd0 || pass_b !== 1'b1) begin
            tests_failed++;
            $display("FAIL w4_clean_rerun: got err=%0d pass=%0b, expected 0/1", err_b, pass_b);
        end
    endtask

    task automatic test_saturate_w3();
        int cycles;
        mode_c = 2'd1;
        run_until_done(2, cycles);
        @(negedge clk);
        tests_run++;
        if (cycles != 25 || err_c !== 2'd3 || pass_c !== 1'b0) begin
            tests_failed++;
            $display("FAIL w3_saturate: got cycles=%0d err=%0d pass=%0b, expected 25/3/0", cycles, err_c, pass_c);
        end
    endtask

    task automatic test_reset_mid_run();
        int  cycles;
        bit  found;
        mode_c = 2'd1;
        found  = 1'b0;
        @(negedge clk);
        start_c = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            start_c = 1'b0;
            if (busy_c && stim_c == 3'd5) begin
                found = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!found || err_c !== 2'd3) begin
            tests_failed++;
            $display("FAIL midrun_reach: got found=%0b err=%0d, expected 1/3", found, err_c);
        end
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if (stim_c !== 3'd0 || busy_c !== 1'b0 || done_c !== 1'b0 || err_c !== 2'd0 || pass_c !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrun_async_reset: got stim=%0h busy=%0b done=%0b err=%0d pass=%0b, expected all 0",
                     stim_c, busy_c, done_c, err_c, pass_c);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++;
            if (done_c !== 1'b0 || busy_c !== 1'b0) begin
                tests_failed++;
                $display("FAIL midrun_held: got busy=%0b done=%0b, expected 0/0", busy_c, done_c);
            end
        end
        rst_n  = 1'b1;
        mode_c = 2'd0;
        run_until_done(2, cycles);
        @(negedge clk);
        tests_run++;
        if (cycles != 25 || err_c !== 2'd0 || pass_c !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrun_restart: got cycles=%0d err=%0d pass=%0b, expected 25/0/1", cycles, err_c, pass_c);
        end
    endtask

    task automatic test_back_to_back();
        int n_done;
        int first_done;
        logic [31:0] done_mask;
        // re-pulsing start while busy must not queue a second run
        n_done     = 0;
        first_done = 0;
        @(negedge clk);
        start_a = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (done_a) begin
                n_done++;
                if (first_done == 0) first_done = cyc;
            end
            start_a = (cyc == 3 || cyc == 4);
        end
        start_a = 1'b0;
        tests_run++;
        if (n_done != 1 || first_done != 7) begin
            tests_failed++;
            $display("FAIL busy_start_ignored: got %0d done pulses first at %0d, expected 1 at 7", n_done, first_done);
        end
        // start held high: second run accepted in the idle cycle after DONE
        done_mask = '0;
        @(negedge clk);
        start_a = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (done_a) done_mask[cyc] = 1'b1;
            if (cyc == 8) begin
                tests_run++;
                if (busy_a !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL held_gap cyc8: got busy=%0b, expected 0", busy_a);
                end
            end
            if (cyc == 9) begin
                tests_run++;
                if (busy_a !== 1'b1 || stim_a !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL held_restart cyc9: got busy=%0b stim=%0b, expected 1/0", busy_a, stim_a);
                end
            end
            if (cyc == 10) start_a = 1'b0;
        end
        tests_run++;
        if (done_mask !== ((32'd1 << 7) | (32'd1 << 15))) begin
            tests_failed++;
            $display("FAIL held_done_cycles: got mask=%08h, expected %08h", done_mask, (32'd1 << 7) | (32'd1 << 15));
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        mode_b  = 2'd0;
        mode_c  = 2'd0;
        test_reset();
        test_inverter_w1();
        test_buffer_w4();
        test_stuck_w4();
        test_saturate_w3();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
